// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
//   Iterative multiply/divide unit for the EX stage. Executes MULT, MULTU,
//   DIV and DIVU one bit per cycle and returns a {hi, lo} pair for the HI/LO
//   register file.
//
//   Handshake: start is sampled only while idle (busy=0). busy rises on the
//   edge after acceptance and falls on the edge that raises valid. valid is a
//   single-cycle pulse, and a new start is accepted in that same cycle.
//   flush aborts any operation in progress without touching hi/lo.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   operation request (sampled in IDLE)
//   op     in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a      in   multiplicand / dividend
//   b      in   multiplier / divisor
//   flush  in   abort current operation
//   busy   out  operation in progress
//   valid  out  one-cycle result pulse
//   hi     out  MULT: upper product half, DIV: remainder
//   lo     out  MULT: lower product half, DIV: quotient
// -----------------------------------------------------------------------------
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    // PREP performs the first iteration, CALC the remaining WIDTH-1.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t               state;
    logic [1:0]           op_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;

    // Operand decode, derived from the latched request.
    logic                 is_div;
    logic                 is_signed;
    logic                 neg_a;
    logic                 neg_b;
    logic                 sign_q;
    logic                 sign_r;
    logic                 div_zero;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;

    // One iteration of the datapath.
    logic [2*WIDTH-1:0]   acc_init;
    logic [2*WIDTH-1:0]   acc_src;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_top;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   acc_step;

    // Sign correction applied in FIX.
    logic [2*WIDTH-1:0]   prod_neg;
    logic [WIDTH-1:0]     quo_neg;
    logic [WIDTH-1:0]     rem_neg;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    always_comb begin
        is_div    = op_r[1];
        is_signed = ~op_r[0];
        neg_a     = is_signed & a_r[WIDTH-1];
        neg_b     = is_signed & b_r[WIDTH-1];
        sign_q    = neg_a ^ neg_b;
        sign_r    = neg_a;
        div_zero  = is_div && (b_r == '0);
        // Negating the most-negative value yields 2^(WIDTH-1) when read as unsigned.
        mag_a     = neg_a ? ('0 - a_r) : a_r;
        mag_b     = neg_b ? ('0 - b_r) : b_r;
    end

    always_comb begin
        // Multiply: upper half accumulates, lower half holds the multiplier
        // being shifted out. Divide: upper half is the partial remainder,
        // lower half shifts dividend bits out and quotient bits in.
        acc_init = is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
        acc_src  = (state == PREP) ? acc_init : acc;

        mul_sum  = {1'b0, acc_src[2*WIDTH-1:WIDTH]}
                 + (acc_src[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});

        div_top  = acc_src[2*WIDTH-1:WIDTH-1];
        div_diff = div_top - {1'b0, mag_b};

        if (is_div) begin
            // Borrow out of the trial subtraction means restore.
            if (div_diff[WIDTH])
                acc_step = {div_top[WIDTH-1:0], acc_src[WIDTH-2:0], 1'b0};
            else
                acc_step = {div_diff[WIDTH-1:0], acc_src[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_src[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_neg = '0 - acc;
        quo_neg  = '0 - acc[WIDTH-1:0];
        rem_neg  = '0 - acc[2*WIDTH-1:WIDTH];
        if (is_div) begin
            fix_hi = sign_r ? rem_neg : acc[2*WIDTH-1:WIDTH];
            fix_lo = sign_q ? quo_neg : acc[WIDTH-1:0];
        end else begin
            fix_hi = sign_q ? prod_neg[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            fix_lo = sign_q ? prod_neg[WIDTH-1:0]       : acc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            valid <= 1'b0;
            if (flush && state != IDLE) begin
                // Abort: results registers keep the previous completion.
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !flush) begin
                            op_r  <= op;
                            a_r   <= a;
                            b_r   <= b;
                            busy  <= 1'b1;
                            state <= PREP;
                        end
                    end
                    PREP: begin
                        if (div_zero) begin
                            lo    <= '1;
                            hi    <= a_r;
                            valid <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            acc   <= acc_step;
                            cnt   <= '0;
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        acc <= acc_step;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_CNT)
                            state <= FIX;
                    end
                    FIX: begin
                        hi    <= fix_hi;
                        lo    <= fix_lo;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// -----------------------------------------------------------------------------
// tb_muldiv_iter
//   Directed bench for muldiv_iter (WIDTH=32). The driver pushes the expected
//   {hi, lo} for each issued operation into exp_q; a monitor on the falling
//   edge pops and compares whenever valid is seen. The driver separately
//   checks latency, busy duration, flush and reset behaviour.
// -----------------------------------------------------------------------------
module tb_muldiv_iter;

    localparam int W   = 32;
    localparam int LAT = W + 2;   // valid-cycle index, start-sampled cycle = 0

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          flush;
    logic          busy;
    logic          valid;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] exp_e;

    muldiv_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .valid (valid),
        .hi    (hi),
        .lo    (lo)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- compare helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got hi=%h lo=%h, required no result", hi, lo);
            end else begin
                exp_e = exp_q.pop_front();
                check("result_hi", 64'(hi), 64'(exp_e[2*W-1:W]));
                check("result_lo", 64'(lo), 64'(exp_e[W-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issue one operation and track its handshake. With chain=1 the start is
    // raised immediately, i.e. in the valid cycle of the previous operation.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el,
                          input int lat, input bit chain);
        int busy_cnt;
        bit got;
        busy_cnt = 0;
        got      = 1'b0;
        if (!chain) @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        exp_q.push_back({eh, el});
        for (int k = 1; k <= 100 && !got; k++) begin
            @(negedge clk);
            // Scramble operands and poke start mid-operation: neither may
            // disturb the operation already accepted.
            start = (k == 4);
            a     = $urandom;
            b     = $urandom;
            op    = 2'($urandom_range(0, 3));
            if (k == 1) check("busy_after_start", 64'(busy), 64'(1));
            if (valid) begin
                got = 1'b1;
                check("latency", 64'(k), 64'(lat));
                check("busy_in_valid", 64'(busy), 64'(0));
            end else if (busy) begin
                busy_cnt++;
            end
        end
        start = 1'b0;
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: got no valid in 100 cycles, required valid at cycle %0d", lat);
        end
        check("busy_cycles", 64'(busy_cnt), 64'(lat - 1));
    endtask

    // Start a DIV and flush it in cycle 'off' after the start edge.
    task automatic flush_op(input int off, input logic [W-1:0] keep_hi, input logic [W-1:0] keep_lo);
        int vcnt;
        vcnt = 0;
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd100;
        b     = 32'd3;
        for (int k = 1; k <= off; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("busy_before_flush", 64'(busy), 64'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        repeat (40) begin
            @(negedge clk);
            if (valid) vcnt++;
        end
        check("flush_no_valid", 64'(vcnt), 64'(0));
        check("flush_hi_kept", 64'(hi), 64'(keep_hi));
        check("flush_lo_kept", 64'(lo), 64'(keep_lo));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int vcnt;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",  64'(busy),  64'(0));
        check("reset_valid", 64'(valid), 64'(0));
        check("reset_hi",    64'(hi),    64'(0));
        check("reset_lo",    64'(lo),    64'(0));
        rst = 1'b0;

        // Multiplies
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT, 1'b0);
        run_op(2'b00, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, LAT, 1'b1);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, LAT, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, LAT, 1'b0);

        // Divides (hi = remainder, lo = quotient)
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, LAT, 1'b0);
        run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, LAT, 1'b0);
        run_op(2'b11, 32'd64,        32'd7,         32'h0000_0001, 32'h0000_0009, LAT, 1'b0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, LAT, 1'b0);

        // Divide by zero
        run_op(2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 2, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 2, 1'b1);

        // Establish hi=1, lo=2, then flush mid-CALC and in the FIX cycle
        run_op(2'b11, 32'd15, 32'd7, 32'h0000_0001, 32'h0000_0002, LAT, 1'b0);
        flush_op(10, 32'h0000_0001, 32'h0000_0002);
        flush_op(LAT - 1, 32'h0000_0001, 32'h0000_0002);

        // flush together with start in IDLE drops the start
        vcnt = 0;
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b01;
        a     = 32'd3;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("idle_flush_busy", 64'(busy), 64'(0));
        repeat (40) begin
            @(negedge clk);
            if (valid) vcnt++;
        end
        check("idle_flush_no_valid", 64'(vcnt), 64'(0));
        check("idle_flush_hi", 64'(hi), 64'(1));
        check("idle_flush_lo", 64'(lo), 64'(2));

        // Asynchronous reset between edges during CALC
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_rst", 64'(busy), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy",  64'(busy),  64'(0));
        check("async_rst_valid", 64'(valid), 64'(0));
        check("async_rst_hi",    64'(hi),    64'(0));
        check("async_rst_lo",    64'(lo),    64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(2'b11, 32'd64, 32'd7, 32'h0000_0001, 32'h0000_0009, LAT, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
